// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: opcodes, FSM encoding, flag bit positions.
package alu_pkg;

  // ARM data-processing cmd field encodings handled by the unit
  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_EOR = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_ADD = 4'b0100;
  localparam logic [3:0] OP_TST = 4'b1000;
  localparam logic [3:0] OP_CMP = 4'b1010;
  localparam logic [3:0] OP_ORR = 4'b1100;
  localparam logic [3:0] OP_MOV = 4'b1101;
  localparam logic [3:0] OP_MVN = 4'b1111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Bit positions inside the {N,Z,C,V} flag register
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/alu_comb.sv
// Single-cycle ALU slice: result, NZCV candidates and op classification.
module alu_comb
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [3:0]       i_op,
  output logic [WIDTH-1:0] o_result,
  output logic [3:0]       o_nzcv,
  output logic             o_we,
  output logic             o_valid,
  output logic             o_arith,
  output logic             o_force_flags
);

  logic [WIDTH:0] w_sum;
  logic [WIDTH:0] w_dif;
  logic           w_c;
  logic           w_v;

  // Subtraction as A + ~B + 1 so the carry-out is directly NOT borrow
  assign w_sum = {1'b0, i_a} + {1'b0, i_b};
  assign w_dif = {1'b0, i_a} + {1'b0, ~i_b} + {{WIDTH{1'b0}}, 1'b1};

  // Decode the opcode into result, writeback enable and flag candidates
  always_comb begin
    // NOTE: every output gets a default first so no path leaves a latch behind.
    o_result      = '0;
    o_we          = 1'b0;
    o_valid       = 1'b1;
    o_arith       = 1'b0;
    o_force_flags = 1'b0;
    w_c           = 1'b0;
    w_v           = 1'b0;
    case (i_op)
      OP_AND: begin o_result = i_a & i_b; o_we = 1'b1; end
      OP_EOR: begin o_result = i_a ^ i_b; o_we = 1'b1; end
      OP_ORR: begin o_result = i_a | i_b; o_we = 1'b1; end
      OP_MOV: begin o_result = i_b;       o_we = 1'b1; end
      OP_MVN: begin o_result = ~i_b;      o_we = 1'b1; end
      OP_TST: begin o_result = i_a & i_b; o_force_flags = 1'b1; end
      OP_ADD: begin
        o_result = w_sum[WIDTH-1:0];
        o_we     = 1'b1;
        o_arith  = 1'b1;
        w_c      = w_sum[WIDTH];
        w_v      = (i_a[WIDTH-1] == i_b[WIDTH-1]) && (w_sum[WIDTH-1] != i_a[WIDTH-1]);
      end
      OP_SUB, OP_CMP: begin
        o_result      = w_dif[WIDTH-1:0];
        o_we          = (i_op == OP_SUB);
        o_force_flags = (i_op == OP_CMP);
        o_arith       = 1'b1;
        w_c           = w_dif[WIDTH];
        w_v           = (i_a[WIDTH-1] != i_b[WIDTH-1]) && (w_dif[WIDTH-1] != i_a[WIDTH-1]);
      end
      default: o_valid = 1'b0;
    endcase
    o_nzcv = {o_result[WIDTH-1], (o_result == '0), w_c, w_v};
  end

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with valid/ready handshakes, S-bit gated NZCV register and
// an iterative shift-add multiplier taking WIDTH cycles.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             CLK,
  input  logic             RESETn,
  input  logic             InValid,
  output logic             InReady,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  input  logic [3:0]       ALUOp,
  input  logic             MulEn,
  input  logic             SBit,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [WIDTH-1:0] ALUResult,
  output logic             ResultWE,
  output logic [3:0]       ALUFlags
);

  state_t           r_state;
  logic             r_in_ready;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_result;
  logic             r_we;
  logic [3:0]       r_flags;
  logic [WIDTH-1:0] r_ma;
  logic [WIDTH-1:0] r_mb;
  logic             r_ms;
  logic [WIDTH-1:0] r_acc;
  logic [CNT_W-1:0] r_cnt;

  logic [WIDTH-1:0] w_res;
  logic [3:0]       w_nzcv;
  logic             w_we;
  logic             w_valid;
  logic             w_arith;
  logic             w_force;
  logic [WIDTH-1:0] w_acc_next;
  logic             w_last;

  alu_comb #(.WIDTH(WIDTH)) u_comb (
    .i_a          (SrcA),
    .i_b          (SrcB),
    .i_op         (ALUOp),
    .o_result     (w_res),
    .o_nzcv       (w_nzcv),
    .o_we         (w_we),
    .o_valid      (w_valid),
    .o_arith      (w_arith),
    .o_force_flags(w_force)
  );

  assign w_acc_next = r_acc + (r_mb[0] ? r_ma : '0);
  assign w_last     = (r_cnt == CNT_W'(WIDTH - 1));

  assign InReady   = r_in_ready;
  assign OutValid  = r_out_valid;
  assign ALUResult = r_result;
  assign ResultWE  = r_we;
  assign ALUFlags  = r_flags;

  // Control FSM plus multiplier datapath and flag register, all on one edge
  always_ff @(posedge CLK) begin
    // NOTE: state is written with <= only, so every register samples pre-edge values.
    if (!RESETn) begin
      r_state     <= S_IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_we        <= 1'b0;
      r_flags     <= 4'b0000;
      r_ma        <= '0;
      r_mb        <= '0;
      r_ms        <= 1'b0;
      r_acc       <= '0;
      r_cnt       <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (InValid) begin
            r_in_ready <= 1'b0;
            if (MulEn) begin
              r_ma    <= SrcA;
              r_mb    <= SrcB;
              r_ms    <= SBit;
              r_acc   <= '0;
              r_cnt   <= '0;
              r_state <= S_MUL;
            end else begin
              r_result    <= w_res;
              r_we        <= w_we;
              r_out_valid <= 1'b1;
              r_state     <= S_DONE;
              if (w_valid && (SBit || w_force)) begin
                r_flags[FLAG_N] <= w_nzcv[FLAG_N];
                r_flags[FLAG_Z] <= w_nzcv[FLAG_Z];
                if (w_arith) begin
                  r_flags[FLAG_C] <= w_nzcv[FLAG_C];
                  r_flags[FLAG_V] <= w_nzcv[FLAG_V];
                end
              end
            end
          end
        end
        S_MUL: begin
          r_acc <= w_acc_next;
          r_ma  <= r_ma << 1;
          r_mb  <= r_mb >> 1;
          r_cnt <= r_cnt + CNT_W'(1);
          if (w_last) begin
            r_result    <= w_acc_next;
            r_we        <= 1'b1;
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
            if (r_ms) begin
              r_flags[FLAG_N] <= w_acc_next[WIDTH-1];
              r_flags[FLAG_Z] <= (w_acc_next == '0);
            end
          end
        end
        S_DONE: begin
          if (OutReady) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Registered, parametrised successor to the single-cycle datapath ALU.
- Adds full NZCV flag generation, an S-bit-gated flag register, logic ops, and an iterative shift-add multiplier.
- Uses a valid/ready handshake on both the operand side and the result side.
- Sits between the register-file read stage and writeback in the multi-cycle ARM core.

Parameters:
- WIDTH, 32, operand and result width in bits (≥4).
- CNT_W, $clog2(WIDTH+1), width of the multiply iteration counter.

Ports:
- CLK  in  1  clock; all state changes on rising edge.
- RESETn  in  1  synchronous reset, active-low.
- InValid  in  1  operand bundle valid.
- InReady  out  1  unit can accept a bundle.
- SrcA  in  WIDTH  operand A (multiplicand for MUL).
- SrcB  in  WIDTH  operand B (multiplier for MUL).
- ALUOp  in  4  ARM cmd field.
- MulEn  in  1  1 = MUL, which overrides ALUOp.
- SBit  in  1  set-flags request.
- OutValid  out  1  result valid.
- OutReady  in  1  consumer accepts the result.
- ALUResult  out  WIDTH  registered result.
- ResultWE  out  1  result is to be written back (0 for CMP/TST).
- ALUFlags  out  4  flag register {N,Z,C,V}.

Behaviour:
- Reset (RESETn=0 at edge):
  - State goes to IDLE.
  - ALUResult=0, ALUFlags=4'b0000, OutValid=0, ResultWE=0, InReady=1.
  - Any in-flight operation is discarded.
- Opcodes:
  - AND 0000: A&B. EOR 0001: A^B. SUB 0010: A-B. ADD 0100: A+B.
  - TST 1000: A&B, no writeback. CMP 1010: A-B, no writeback.
  - ORR 1100: A|B. MOV 1101: B. MVN 1111: ~B.
  - Any other code: result 0, ResultWE=0, flags untouched.
- Arithmetic:
  - Computed at WIDTH+1 bits.
  - ADD: C = carry-out. SUB/CMP: C = NOT borrow (A≥B unsigned).
  - V = signed overflow per ARM rules.
  - N = result[WIDTH-1]; Z = (result==0).
  - Logic ops, MOV, MVN: update N and Z only; C and V are preserved.
- Flag update:
  - Flags update when (SBit=1 and op is valid) or op is CMP/TST.
  - Update happens in the same edge that loads ALUResult.
  - MUL with SBit updates N and Z; C and V are preserved.
- FSM states: IDLE, MUL, DONE.
- IDLE:
  - InReady=1.
  - InValid&&!MulEn: compute, load ALUResult, ResultWE and flags, then go to DONE. Latency is 1 cycle.
  - InValid&&MulEn: latch A, B and SBit, clear the accumulator, set cnt=0, go to MUL.
- MUL:
  - InReady=0.
  - Each cycle: if B[0], acc += A (mod 2^WIDTH); A <<= 1; B >>= 1; cnt++.
  - When cnt==WIDTH-1 on an iteration edge, load ALUResult with the final acc, set ResultWE=1, go to DONE.
  - Total latency from acceptance to OutValid is WIDTH cycles.
  - No early termination. Result is the low WIDTH bits only.
- DONE:
  - OutValid=1, InReady=0.
  - OutReady=1: go to IDLE, OutValid falls the next cycle.
  - ALUResult and ALUFlags hold stable while OutValid=1 and OutReady=0.
  - No new acceptance on the same cycle as the OutReady handshake, so one bubble cycle per op.
- ALUFlags persists across operations until its next qualified update.
- InValid is ignored whenever InReady=0.
- Reset asserted during MUL or DONE aborts the operation; no OutValid is produced for it.

Decomposition:
- alu_pkg:
  - Opcode localparams OP_AND … OP_MVN.
  - FSM state encoding (2 bits: S_IDLE, S_MUL, S_DONE).
  - Flag bit indices FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0.
- Sub-module alu_comb:
  - Combinational result plus NZCV for single-cycle ops, parametrised by WIDTH.
  - alu_seq instantiates it and owns the FSM, multiplier datapath and flag register.

Test Plan:
- Reset, then ADD A=32'h7FFFFFFF, B=1, SBit=1 → after 1 cycle OutValid=1, ALUResult=32'h80000000, ALUFlags=4'b1001, ResultWE=1.
- CMP A=5, B=5, SBit=0 → ALUResult=0, ALUFlags=4'b0110 (Z,C), ResultWE=0. Then MOV B=0, SBit=0 → ALUFlags stays 4'b0110.
- MUL A=7, B=6 → OutValid exactly 32 cycles after acceptance, ALUResult=42. Also MUL A=32'hFFFFFFFF, B=2 → 32'hFFFFFFFE; with SBit=1, N=1, Z=0, C/V unchanged.
- Backpressure: hold OutReady=0 for 5 cycles in DONE → ALUResult/ALUFlags stable, InReady=0, a new InValid is ignored. Raise OutReady → IDLE next cycle, the pending op is accepted.
- RESETn=0 at MUL iteration 10 → next cycle IDLE, OutValid=0, ALUFlags=0, ALUResult=0. A subsequent SUB A=3, B=5, SBit=1 → ALUResult=32'hFFFFFFFE, ALUFlags=4'b1000.
- Unused ALUOp 4'b0111 with SBit=1 → ALUResult=0, ResultWE=0, ALUFlags unchanged.
